regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port register file for the pipelined processor, the successor to the fixed 64x32, 2-read/1-write file. It adds configurable width, depth and read-port count, and a second write port for the load/ALU writeback split. Per-register pending bits form an issue scoreboard. A self-sequenced initialisation walk runs after reset. It sits between decode (read ports, scoreboard marks) and writeback (both write ports).

## Interface
Parameters:
- WIDTH, 64, data word width in bits
- DEPTH, 32, number of registers (power of two, ≥4); AW = $clog2(DEPTH)
- NREAD, 2, number of read ports (1..4)
- ZERO_REG, DEPTH-1, hardwired-zero register index
- INIT_MODE, 1, post-reset contents: 0 = all zero, 1 = reg[i] = i (ZERO_REG always 0)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- init_busy  out  1  high while the initialisation walk runs
- ra  in  NREAD*AW  read addresses; port p occupies bits [p*AW +: AW]
- rd  out  NREAD*WIDTH  read data; port p occupies bits [p*WIDTH +: WIDTH]
- rd_pending  out  NREAD  pending bit of register ra[p]
- we_a, wa_a, wd_a  in  1/AW/WIDTH  write port A (ALU writeback)
- we_b, wa_b, wd_b  in  1/AW/WIDTH  write port B (load writeback)
- mark_en, mark_addr  in  1/AW  set the pending bit of mark_addr (instruction issue)

## Operation
- Reset, sampled high at an edge: clears the init counter to 0, sets init_busy=1 and clears all pending bits. Array contents are not cleared directly; the walk rewrites them.
- Init walk: at each edge with reset=0 and init_busy=1, write reg[cnt] = (INIT_MODE ? cnt : 0), then cnt++. At the edge that writes reg[DEPTH-1], init_busy goes low. ZERO_REG is written with 0.
- While init_busy=1:
  - we_a, we_b and mark_en are ignored.
  - rd outputs 0 and rd_pending outputs 0.
- Writes: at each edge where we_x=1 and wa_x≠ZERO_REG, reg[wa_x] <= wd_x. If both ports target the same address, port B wins.
- Reads are combinational with write-through bypass, evaluated per port p:
  - ra[p]==ZERO_REG → 0.
  - Else if we_b && wa_b==ra[p] → wd_b.
  - Else if we_a && wa_a==ra[p] → wd_a.
  - Else → reg[ra[p]].
- Scoreboard, per register r at each edge:
  - Set if mark_en && mark_addr==r.
  - Else clear if (we_a && wa_a==r) or (we_b && wa_b==r).
  - Mark wins over a same-cycle write to the same register.
  - ZERO_REG is never pending.
- rd_pending[p] is the registered pending bit, masked to 0 if a same-cycle write to ra[p] would clear it. This is consistent with the bypass.

## Timing
- Write latency: data is visible on rd in the same cycle via bypass, and from the array from the next cycle on.
- Pending latency: a mark at edge k is visible on rd_pending after edge k.
- Init duration: exactly DEPTH edges after the first edge with reset=0. init_busy is high from the reset edge through those DEPTH edges.
- Reset asserted mid-walk: the walk restarts from cnt=0 at the next edge with reset=0.
- All outputs after reset: init_busy=1, rd=0, rd_pending=0.
- No internal registers on read paths; rd and rd_pending are purely combinational from state and inputs.

## Test plan
- Default parameters: pulse reset 1 cycle → init_busy high for exactly 32 edges after deassertion. Then ra0=5 → rd0=5; ra0=31 → rd0=0.
- Dual write collision: after init, we_a=we_b=1, wa_a=wa_b=7, wd_a=0xAA, wd_b=0xBB → rd=0xBB same cycle; reg[7] reads 0xBB the next cycle.
- Zero register: we_a=1, wa_a=31, wd_a=0xFF → rd for ra=31 stays 0 in the same and following cycle; mark_en on 31 → rd_pending stays 0.
- Scoreboard: mark reg 3 → rd_pending=1 next cycle. we_a to 3 → rd_pending=0 in the same cycle (masked), and pending clears after the edge. Mark plus write to 3 in the same cycle → pending remains 1.
- Mid-init reset: assert reset at cnt=10 → the walk restarts and init_busy stays high for 32 more edges. Writes with we_a=1 during the walk are ignored, so reg[4] reads 4 after init.
- Parametric: WIDTH=32, DEPTH=16, NREAD=3, INIT_MODE=0 → 16-edge init, all three read ports return 0. Independent bypass per port: ra={2,2,5} with we_a to reg 2 → rd={wd_a, wd_a, 0}.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NREAD combinational read ports with
// write-through bypass, a per-register issue scoreboard and a post-reset init walk.
module regfile_mp #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 32,
  parameter int NREAD     = 2,
  parameter int ZERO_REG  = DEPTH - 1,
  parameter int INIT_MODE = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   init_busy,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] rd,
  output logic [NREAD-1:0]       rd_pending,
  input  logic                   we_a,
  input  logic [AW-1:0]          wa_a,
  input  logic [WIDTH-1:0]       wd_a,
  input  logic                   we_b,
  input  logic [AW-1:0]          wa_b,
  input  logic [WIDTH-1:0]       wd_b,
  input  logic                   mark_en,
  input  logic [AW-1:0]          mark_addr
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    init_cnt_reg;
  logic             init_busy_reg;
  logic [DEPTH-1:0] pending_reg;
  logic [DEPTH-1:0] pending_next;

  logic             upd_en;
  logic             wr_a_ok;
  logic             wr_b_ok;
  logic [WIDTH-1:0] init_value;

  // Normal-mode traffic is only honoured once the walk has finished.
  assign upd_en     = ~init_busy_reg;
  assign wr_a_ok    = upd_en & ~reset & we_a & (wa_a != ZERO_ADDR);
  assign wr_b_ok    = upd_en & ~reset & we_b & (wa_b != ZERO_ADDR);
  assign init_value = ((INIT_MODE != 0) && (init_cnt_reg != ZERO_ADDR)) ?
                      WIDTH'(init_cnt_reg) : '0;
  assign init_busy  = init_busy_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      init_cnt_reg  <= '0;
      init_busy_reg <= 1'b1;
    end else if (init_busy_reg) begin
      init_cnt_reg <= init_cnt_reg + 1'b1;
      if (init_cnt_reg == LAST_ADDR) begin
        init_busy_reg <= 1'b0;
      end
    end
  end

  // Port B is written last so it wins an address collision with port A.
  always_ff @(posedge clk) begin
    if (!reset && init_busy_reg) begin
      mem[init_cnt_reg] <= init_value;
    end else begin
      if (wr_a_ok) begin
        mem[wa_a] <= wd_a;
      end
      if (wr_b_ok) begin
        mem[wa_b] <= wd_b;
      end
    end
  end

  genvar gi;

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_sb
      logic mark_hit;
      logic clr_hit;

      assign mark_hit = upd_en & mark_en & (mark_addr == AW'(gi));
      assign clr_hit  = upd_en & ((we_a & (wa_a == AW'(gi))) |
                                  (we_b & (wa_b == AW'(gi))));

      if (gi == ZERO_REG) begin : g_zero
        assign pending_next[gi] = 1'b0;
      end else begin : g_norm
        assign pending_next[gi] = mark_hit ? 1'b1 :
                                  clr_hit  ? 1'b0 : pending_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_rp
      logic [AW-1:0]    addr;
      logic             hit_a;
      logic             hit_b;
      logic             mark_hit;
      logic [WIDTH-1:0] data;

      assign addr     = ra[gi*AW +: AW];
      assign hit_a    = we_a & (wa_a == addr);
      assign hit_b    = we_b & (wa_b == addr);
      assign mark_hit = mark_en & (mark_addr == addr);

      assign data = (init_busy_reg || addr == ZERO_ADDR) ? '0 :
                    hit_b ? wd_b :
                    hit_a ? wd_a : mem[addr];

      // A write in flight retires the pending bit this cycle unless it is re-marked.
      assign rd[gi*WIDTH +: WIDTH] = data;
      assign rd_pending[gi] = ~init_busy_reg & pending_reg[addr] &
                              ~((hit_a | hit_b) & ~mark_hit);
    end
  endgenerate

endmodule
